// File: rtl/accelerator_read_modes_softmax.sv
// accelerator_read_modes_softmax: per-head softmax over MODES logits using
// max-subtraction, a base-2 exponential approximation and a restoring divider.
module accelerator_read_modes_softmax #(
   parameter int     DATA_SIZE    = 64,
   parameter int     CONTROL_SIZE = 64,
   parameter int     FRAC_BITS    = 16,
   parameter int     MODES        = 3,
   parameter longint LOG2E        = $rtoi(1.442695 * (2.0 ** FRAC_BITS) + 0.5)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic                 ready,
   input  logic [DATA_SIZE-1:0] size_r_in,
   input  logic                 pi_in_enable,
   input  logic [DATA_SIZE-1:0] pi_in,
   output logic                 pi_out_i_enable,
   output logic                 pi_out_p_enable,
   output logic [DATA_SIZE-1:0] pi_out
);
   localparam int MW = $clog2(MODES);
   localparam int IW = $clog2(FRAC_BITS + 1);
   localparam int SW = $clog2(DATA_SIZE);
   localparam int PW = 2 * DATA_SIZE + 2;
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_EXP  = 3'd2;
   localparam logic [2:0] S_DIV  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;
   localparam logic [CONTROL_SIZE-1:0] LAST_M = CONTROL_SIZE'(MODES - 1);
   localparam logic [CONTROL_SIZE-1:0] ONE_C  = CONTROL_SIZE'(1);
   localparam logic [IW-1:0] LAST_IT = IW'(FRAC_BITS);
   localparam logic signed [DATA_SIZE:0] L2E = (DATA_SIZE + 1)'(LOG2E);

   logic [2:0]              state;
   logic [DATA_SIZE-1:0]    r, mx, sum;
   logic [CONTROL_SIZE-1:0] head, m, head_nx;
   logic [IW-1:0]           it;
   logic [DATA_SIZE-1:0]    lbuf [MODES];
   logic [DATA_SIZE:0]      rem, rem_sub;
   logic [FRAC_BITS:0]      quo, q_nx;
   logic [MW-1:0]           mi;
   logic signed [DATA_SIZE:0] d;
   logic signed [PW-1:0]    t, nk;
   logic [DATA_SIZE-1:0]    e;
   logic                    ge, bigger;

   always_comb begin
      mi      = m[MW-1:0];
      d       = $signed({lbuf[mi][DATA_SIZE-1], lbuf[mi]}) - $signed({mx[DATA_SIZE-1], mx});
      t       = (PW'(d) * PW'(L2E)) >>> FRAC_BITS;
      nk      = -(t >>> FRAC_BITS);
      // 2^(k+f) = (1.f) >> -k; anything shifted past the word is zero
      e       = (nk >= PW'(DATA_SIZE)) ? '0 : DATA_SIZE'({1'b1, t[FRAC_BITS-1:0]}) >> nk[SW-1:0];
      ge      = rem >= {1'b0, sum};
      rem_sub = ge ? rem - {1'b0, sum} : rem;
      q_nx    = {quo[FRAC_BITS-1:0], ge};
      head_nx = head + ONE_C;
      bigger  = $signed(pi_in) > $signed(mx);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         r               <= '0;
         mx              <= '0;
         sum             <= '0;
         head            <= '0;
         m               <= '0;
         it              <= '0;
         rem             <= '0;
         quo             <= '0;
         lbuf            <= '{default: '0};
         ready           <= 1'b0;
         pi_out_i_enable <= 1'b0;
         pi_out_p_enable <= 1'b0;
         pi_out          <= '0;
      end else begin
         ready           <= 1'b0;
         pi_out_i_enable <= 1'b0;
         pi_out_p_enable <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               r     <= size_r_in;
               head  <= '0;
               m     <= '0;
               state <= (size_r_in == '0) ? S_DONE : S_LOAD;
            end
            S_LOAD: begin
               sum <= '0;
               if (pi_in_enable) begin
                  lbuf[mi] <= pi_in;
                  mx       <= (m == '0 || bigger) ? pi_in : mx;
                  m        <= (m == LAST_M) ? '0 : m + ONE_C;
                  state    <= (m == LAST_M) ? S_EXP : S_LOAD;
               end
            end
            S_EXP: begin
               // logits are overwritten in place by their exponentials
               lbuf[mi] <= e;
               sum      <= sum + e;
               m        <= m + ONE_C;
               if (m == LAST_M) begin
                  state <= S_DIV;
                  m     <= '0;
                  rem   <= {1'b0, lbuf[0]};
                  quo   <= '0;
                  it    <= '0;
               end
            end
            S_DIV: begin
               rem <= rem_sub << 1;
               quo <= q_nx;
               it  <= it + IW'(1);
               if (it == LAST_IT) begin
                  pi_out          <= DATA_SIZE'(q_nx);
                  pi_out_p_enable <= 1'b1;
                  pi_out_i_enable <= (m == '0);
                  it              <= '0;
                  quo             <= '0;
                  rem             <= {1'b0, lbuf[mi + MW'(1)]};
                  m               <= m + ONE_C;
                  if (m == LAST_M) begin
                     m     <= '0;
                     head  <= head_nx;
                     state <= (DATA_SIZE'(head_nx) < r) ? S_LOAD : S_DONE;
                  end
               end
            end
            S_DONE: begin
               ready <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_accelerator_read_modes_softmax.sv
// tb_accelerator_read_modes_softmax: directed and random jobs scored against
// an arithmetic softmax model built from the exp2/divide rules.
module tb_accelerator_read_modes_softmax;
   localparam int     MD  = 3;
   localparam int     FB  = 16;
   localparam longint ONE = 65536;
   localparam longint L2E = 94548;

   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, pi_in_enable = 1'b0;
   logic        ready, pi_out_i_enable, pi_out_p_enable;
   logic [63:0] size_r_in = '0, pi_in = '0, pi_out;

   int     total = 0, bad = 0, rdy_n = 0, stray = 0;
   longint cyc = 0, rdy_cyc = -1;
   longint got_q[$], out_cyc[$], exp_q[$], lg[$];
   bit     got_i[$];

   accelerator_read_modes_softmax dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .size_r_in(size_r_in),
      .pi_in_enable(pi_in_enable), .pi_in(pi_in), .pi_out_i_enable(pi_out_i_enable),
      .pi_out_p_enable(pi_out_p_enable), .pi_out(pi_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) if (rst_n) begin
      if (pi_out_p_enable) begin
         got_q.push_back(longint'(pi_out));
         got_i.push_back(pi_out_i_enable);
         out_cyc.push_back(cyc);
      end
      if (pi_out_i_enable && !pi_out_p_enable) stray++;
      if (ready) begin
         rdy_n++;
         rdy_cyc = cyc;
      end
   end

   task automatic check(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint exp2_of(input longint dv);
      longint t, k, f;
      t = (dv * L2E) >>> FB;
      k = t >>> FB;
      f = t & (ONE - 1);
      return (-k >= 64) ? 0 : (ONE + f) >> (-k);
   endfunction

   task automatic model_job(input int r);
      longint mx, sum, e[MD];
      exp_q.delete();
      for (int h = 0; h < r; h++) begin
         mx = lg[h*MD];
         for (int k = 1; k < MD; k++) if (lg[h*MD+k] > mx) mx = lg[h*MD+k];
         sum = 0;
         for (int k = 0; k < MD; k++) begin
            e[k] = exp2_of(lg[h*MD+k] - mx);
            sum += e[k];
         end
         for (int k = 0; k < MD; k++) exp_q.push_back((e[k] << FB) / sum);
      end
   endtask

   function automatic longint rnd_logit(input int scale);
      return longint'($urandom_range(0, 2 * scale)) - longint'(scale);
   endfunction

   task automatic set3(input longint a, input longint b, input longint c);
      lg.push_back(a);
      lg.push_back(b);
      lg.push_back(c);
   endtask

   task automatic run_job(input string tag, input int r, input bit abuse);
      longint acc, start_cyc;
      int n;
      got_q.delete(); got_i.delete(); out_cyc.delete();
      rdy_n = 0; rdy_cyc = -1;
      model_job(r);
      start = 1'b1; size_r_in = 64'(r); start_cyc = cyc + 1;
      pi_in_enable = abuse; pi_in = 64'h7fff_0000;
      @(negedge clk);
      start = 1'b0; pi_in_enable = 1'b0;
      for (int h = 0; h < r; h++) begin
         for (int k = 0; k < MD; k++) begin
            pi_in_enable = 1'b1;
            pi_in = 64'(lg[h*MD+k]);
            @(negedge clk);
         end
         pi_in_enable = 1'b0;
         acc = cyc;
         for (int w = 0; got_q.size() < (h + 1) * MD; w++) begin
            if (w >= 200) begin
               check({tag, " timeout"}, got_q.size(), (h + 1) * MD);
               break;
            end
            start        = abuse && w < 40 && w[0];
            size_r_in    = abuse ? 64'd5 : 64'(r);
            pi_in_enable = abuse && w < 40;
            pi_in        = {$urandom, $urandom};
            @(negedge clk);
         end
         start = 1'b0; pi_in_enable = 1'b0; size_r_in = 64'(r);
         if (got_q.size() > h * MD)
            check($sformatf("%s latency h%0d", tag, h), out_cyc[h*MD] - acc, MD + FB + 1);
      end
      for (int w = 0; w < 20 && rdy_n == 0; w++) @(negedge clk);
      repeat (3) @(negedge clk);
      n = got_q.size();
      check({tag, " count"}, n, r * MD);
      check({tag, " ready pulses"}, rdy_n, 1);
      check({tag, " ready time"}, rdy_cyc - ((r > 0 && n > 0) ? out_cyc[n-1] : start_cyc), 1);
      for (int j = 0; j < n && j < exp_q.size(); j++) begin
         check($sformatf("%s w%0d", tag, j), got_q[j], exp_q[j]);
         check($sformatf("%s i_en%0d", tag, j), longint'(got_i[j]), longint'(j % MD == 0));
         if (j % MD != 0) check($sformatf("%s gap%0d", tag, j), out_cyc[j] - out_cyc[j-1], FB + 1);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst pi_out", longint'(pi_out), 0);
      check("rst p_en", longint'(pi_out_p_enable), 0);
      check("rst i_en", longint'(pi_out_i_enable), 0);
      check("rst ready", longint'(ready), 0);
      rst_n = 1'b1;
      @(negedge clk);

      lg.delete(); set3(0, 0, 0);
      run_job("equal", 1, 1'b0);
      if (got_q.size() == 3) for (int j = 0; j < 3; j++) check($sformatf("equal const%0d", j), got_q[j], 21845);

      lg.delete(); set3(0, 0, -4194304); set3(327680, 327680, 327680);
      run_job("underflow", 2, 1'b0);
      if (got_q.size() == 6) begin
         check("underflow h0w0", got_q[0], 32768);
         check("underflow h0w2", got_q[2], 0);
         check("underflow h1w1", got_q[4], 21845);
      end

      lg.delete();
      run_job("zero", 0, 1'b0);

      lg.delete(); set3(655360, 0, 0);
      run_job("dominant", 1, 1'b0);
      if (got_q.size() == 3) begin
         check("dominant big", longint'(got_q[0] >= 65500), 1);
         check("dominant small", longint'(got_q[1] <= 4 && got_q[2] <= 4), 1);
         check("dominant sum", longint'(got_q[0] + got_q[1] + got_q[2] >= ONE - 3), 1);
      end

      start = 1'b1; size_r_in = 64'd1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < MD; k++) begin
         pi_in_enable = 1'b1; pi_in = '0;
         @(negedge clk);
      end
      pi_in_enable = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async pi_out", longint'(pi_out), 0);
      check("async p_en", longint'(pi_out_p_enable), 0);
      check("async ready", longint'(ready), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      lg.delete(); set3(0, 0, 0);
      run_job("post reset", 1, 1'b0);

      lg.delete();
      for (int j = 0; j < 2 * MD; j++) lg.push_back(rnd_logit(4 << 16));
      run_job("abuse", 2, 1'b1);

      for (int i = 0; i < 6; i++) begin
         int r;
         r = int'($urandom_range(1, 3));
         lg.delete();
         for (int j = 0; j < r * MD; j++) lg.push_back(rnd_logit((i % 2 == 0) ? (8 << 16) : (100 << 16)));
         run_job($sformatf("rand%0d", i), r, 1'b0);
      end

      check("stray i_en", stray, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
